// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte stream from the UART receiver, the instruction memory
// write port and the core control/status lines that connect to the boot
// loader.
//   rx_valid  : one-cycle strobe per received byte
//   rx_data   : received byte, valid with rx_valid
//   imem_we   : instruction memory write enable (one-cycle pulse)
//   imem_addr : instruction memory word address
//   imem_wd   : instruction memory write data
//   core_rst  : holds the core and its PC in reset while high
//   done      : image loaded and checksum verified
//   err       : load failed
// Modports:
//   master : the boot loader (consumes bytes, drives memory port and status)
//   slave  : the surrounding system (supplies bytes, observes the rest)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              core_rst;
    logic              done;
    logic              err;

    modport master (
        input  rx_valid, rx_data,
        output imem_we, imem_addr, imem_wd, core_rst, done, err
    );

    modport slave (
        output rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wd, core_rst, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a byte stream and writes it, one 32-bit word
// at a time, into the instruction memory. The core is kept in reset until a
// complete image with a matching XOR checksum has been written.
// Frame: MAGIC, CNT_LO, CNT_HI, CNT little-endian words, CSUM (XOR of the
// payload bytes only).
// Ports:
//   CLK : clock
//   RST : asynchronous active-high reset
//   bus : imem_boot_loader_if master (byte stream in, imem write port and
//         core_rst/done/err out)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          ADDR_W      = 10,
    parameter int          MAX_WORDS   = 1024,
    parameter int          TIMEOUT_CYC = 100000,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic               CLK,
    input  logic               RST,
    imem_boot_loader_if.master bus
);
    // One extra bit so that a count of exactly MAX_WORDS does not wrap.
    localparam int IDX_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      MAX_N    = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [7:0]        cnt_lo_q;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        bcnt_q;
    logic [31:0]       word_q;
    logic [7:0]        acc_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;
    logic              core_rst_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       word_d;
    logic [7:0]        acc_d;
    logic [15:0]       n_d;
    logic              tmo_active;
    logic              tmo_fire;
    logic              last_word;

    always_comb begin
        // Bytes shift in from the top so the first byte ends up in [7:0].
        word_d     = {bus.rx_data, word_q[31:8]};
        acc_d      = acc_q ^ bus.rx_data;
        n_d        = {bus.rx_data, cnt_lo_q};
        tmo_active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
        tmo_fire   = tmo_active && (tmo_q == TMO_LAST);
        last_word  = (idx_q == (n_q - IDX_W'(1)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_lo_q   <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            acc_q      <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;

            if (!tmo_active || bus.rx_valid)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 1'b1;

            // A timeout takes priority: a byte arriving on the same edge is dropped.
            if (tmo_fire) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                tmo_q   <= '0;
            end else if (bus.rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.rx_data == MAGIC) begin
                            state_q <= S_LEN0;
                            idx_q   <= '0;
                            bcnt_q  <= '0;
                            acc_q   <= '0;
                        end
                    end
                    S_LEN0: begin
                        cnt_lo_q <= bus.rx_data;
                        state_q  <= S_LEN1;
                    end
                    S_LEN1: begin
                        if ({1'b0, n_d} > MAX_N) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (n_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            n_q     <= IDX_W'(n_d);
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        word_q <= word_d;
                        acc_q  <= acc_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            we_q   <= 1'b1;
                            addr_q <= idx_q[ADDR_W-1:0];
                            wd_q   <= word_d;
                            idx_q  <= idx_q + IDX_W'(1);
                            if (last_word)
                                state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_data == acc_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    S_DONE: ; // only RST leaves DONE
                    S_ERR: begin
                        if (bus.rx_data == MAGIC) begin
                            state_q <= S_LEN0;
                            err_q   <= 1'b0;
                            idx_q   <= '0;
                            bcnt_q  <= '0;
                            acc_q   <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.imem_we   = we_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_wd   = wd_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Loads a program image from a UART receiver byte stream into the instruction memory write port before the single-cycle core runs. The core is held in reset through its `core_rst` output until a complete, checksum-valid image has been written. Words are written at word addresses, matching instruction fetch by PC[31:2]. The block sits upstream of the instruction memory and the core's PC register.

Parameters:
- ADDR_W, 10, width of the instruction memory word address.
- MAX_WORDS, 1024, largest accepted word count; a header count above this is an error.
- TIMEOUT_CYC, 100000, maximum idle cycles allowed between bytes once a frame has started.
- MAGIC, 8'hA5, frame start byte.

Ports:
- CLK, input, 1, clock.
- RST, input, 1, asynchronous active-high reset.
- rx_valid, input, 1, one-cycle strobe per received byte; back-to-back strobes are legal.
- rx_data, input, 8, received byte; valid when rx_valid=1.
- imem_we, output, 1, instruction memory write enable (one-cycle pulse).
- imem_addr, output, ADDR_W, word address for the write.
- imem_wd, output, 32, write data.
- core_rst, output, 1, holds the core and PC in reset while high.
- done, output, 1, image loaded and verified.
- err, output, 1, load failed.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wd=0, core_rst=1, done=0, err=0. State=IDLE, all counters 0, checksum accumulator 0.
- Frame format: MAGIC, CNT_LO, CNT_HI, then N=CNT words of 4 bytes each (little-endian, first byte goes to [7:0]), then CSUM. CSUM = XOR of all payload bytes only; header bytes are excluded.
- States:
  - IDLE: a byte equal to MAGIC moves to LEN0; any other byte is ignored.
  - LEN0: capture CNT_LO, go to LEN1.
  - LEN1: capture CNT_HI.
    - If N > MAX_WORDS, go to ERR.
    - If N = 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA:
    - Assemble each word with a byte counter 0..3.
    - On the 4th byte, pulse imem_we for exactly one cycle on the following clock. The pulse carries imem_addr = word index (0-based) and imem_wd = the assembled word.
    - After word N-1 is received, go to CSUM.
  - CSUM: if the byte equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: done=1 and core_rst=0, both on the same edge, one cycle after the CSUM byte is accepted. All later bytes are ignored; only RST leaves DONE.
  - ERR:
    - err=1 and core_rst stays 1.
    - A MAGIC byte clears err, resets the word index, byte counter and accumulator, and goes to LEN0.
    - Any other byte is ignored.
- Data register and writes:
  - imem_addr and imem_wd hold their last value between pulses.
  - Words already written before an error are not rolled back; they are simply overwritten by the next load.
- Timeout:
  - In LEN0, LEN1, DATA and CSUM, a counter increments each cycle with rx_valid=0 and clears on rx_valid=1.
  - When the counter reaches TIMEOUT_CYC-1, the next edge enters ERR.
  - The counter is idle (held at 0) in IDLE, DONE and ERR.
- Simultaneous events: a byte arriving in the same cycle the timeout fires is dropped; ERR wins.
- Reset mid-operation: RST at any state returns to IDLE with all reset values, including core_rst=1.
- Word index width is ADDR_W+1 internally so that N = MAX_WORDS does not wrap.

Test Plan:
- Nominal load: bytes A5,02,00,05,00,08,20,00,00,08,AC,89 sent back-to-back. Required: a write of 0x20080005 at address 0, then a write of 0xAC080000 at address 1, each with a one-cycle imem_we. One cycle after the 89 byte, done=1 and core_rst=0.
- Bad checksum: same frame with last byte 88. Required: both writes occur, then err=1, core_rst=1, done=0.
- Recovery from ERR: a valid frame sent after the bad-checksum case. Required: err clears on the A5 byte and the load ends in DONE.
- Empty and oversize frames:
  - A5,00,00,00 gives done=1 with no imem_we pulse.
  - A5,01,04 (N=1025) gives err=1 immediately after the CNT_HI byte.
- Noise and gaps:
  - Bytes 00,FF,13 before A5 are ignored.
  - A gap of TIMEOUT_CYC cycles after the third data byte gives err=1, with no write issued.
- Reset mid-DATA: assert RST after 6 payload bytes. Required: all outputs return to reset values; a fresh valid frame then loads from address 0.
